rename_repair_seq: RTL and testbench

RENAME_REPAIR_SEQ -- requirements
Module: rename_repair_seq

---
 rtl/rename_repair_seq_pkg.sv | 16 +
 rtl/repair_lane.sv | 42 ++++
 rtl/rename_repair_seq.sv | 114 +++++++++++
 tb/tb_rename_repair_seq.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/rename_repair_seq_pkg.sv
// Shared core constants and types for the rename-map repair sequencer.
// Architectural register count and physical tag width are the global sizes the rename block derives from.
package rename_repair_seq_pkg;

  localparam int ARCH_REGS      = 32;
  localparam int ARCH_REG_IDX_W = $clog2(ARCH_REGS);
  localparam int PHYS_TAG_W     = 7;
  localparam int N_REPAIR_LANES = 8;

  typedef enum logic [1:0] {
    REPAIR_IDLE  = 2'd0,
    REPAIR_RUN   = 2'd1,
    REPAIR_DRAIN = 2'd2
  } repair_state_e;

endpackage

// File: rtl/repair_lane.sv
// One lane's registered RMT write slot: captures address/data/enable during a RUN cycle.
// Outside RUN the slot is cleared so no stale write is ever presented.
module repair_lane #(
  parameter int INDEX = 5,
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_i,
  input  logic             we_i,
  input  logic [INDEX-1:0] addr_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [INDEX-1:0] addr_o,
  output logic [WIDTH-1:0] data_o,
  output logic             we_o
);

  logic [INDEX-1:0] r_addr;
  logic [WIDTH-1:0] r_data;
  logic             r_we;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_addr <= '0;
      r_data <= '0;
      r_we   <= 1'b0;
    end else if (load_i) begin
      r_addr <= addr_i;
      r_data <= data_i;
      r_we   <= we_i;
    end else begin
      r_addr <= '0;
      r_data <= '0;
      r_we   <= 1'b0;
    end
  end

  assign addr_o = r_addr;
  assign data_o = r_data;
  assign we_o   = r_we;

endmodule

// File: rtl/rename_repair_seq.sv
// Restores the rename map table from the architectural map, N_PACKETS entries per cycle.
// Reads the AMT combinationally in RUN and presents the registered writes one cycle later.
module rename_repair_seq
  import rename_repair_seq_pkg::*;
#(
  parameter int DEPTH     = ARCH_REGS,
  parameter int INDEX     = ARCH_REG_IDX_W,
  parameter int WIDTH     = PHYS_TAG_W,
  parameter int N_PACKETS = N_REPAIR_LANES
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       recoverFlag_i,
  output logic [N_PACKETS*INDEX-1:0] amtAddr_o,
  input  logic [N_PACKETS*WIDTH-1:0] amtData_i,
  output logic [N_PACKETS*INDEX-1:0] repairAddr_o,
  output logic [N_PACKETS*WIDTH-1:0] repairData_o,
  output logic [N_PACKETS-1:0]       repairWe_o,
  output logic                       repairBusy_o,
  output logic                       repairDone_o
);

  repair_state_e    r_state;
  repair_state_e    w_state_nxt;
  logic [INDEX:0]   r_base;
  logic [INDEX:0]   w_base_nxt;
  logic [31:0]      w_base_ext;
  logic [31:0]      w_base_adv;
  logic             w_run;
  logic             w_last;

  assign w_base_ext = 32'(r_base);
  assign w_base_adv = w_base_ext + 32'(N_PACKETS);
  assign w_last     = (w_base_adv >= 32'(DEPTH));
  assign w_run      = (r_state == REPAIR_RUN);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= REPAIR_IDLE;
      r_base  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_base  <= w_base_nxt;
    end
  end

  // A new recover request always wins and restarts from entry 0.
  always_comb begin
    w_state_nxt = r_state;
    w_base_nxt  = r_base;
    case (r_state)
      REPAIR_IDLE: begin
        if (recoverFlag_i) begin
          w_state_nxt = REPAIR_RUN;
          w_base_nxt  = '0;
        end
      end
      REPAIR_RUN: begin
        if (recoverFlag_i) begin
          w_state_nxt = REPAIR_RUN;
          w_base_nxt  = '0;
        end else if (w_last) begin
          w_state_nxt = REPAIR_DRAIN;
          w_base_nxt  = '0;
        end else begin
          w_base_nxt  = w_base_adv[INDEX:0];
        end
      end
      REPAIR_DRAIN: begin
        w_base_nxt = '0;
        if (recoverFlag_i) begin
          w_state_nxt = REPAIR_RUN;
        end else begin
          w_state_nxt = REPAIR_IDLE;
        end
      end
      default: begin
        w_state_nxt = REPAIR_IDLE;
        w_base_nxt  = '0;
      end
    endcase
  end

  assign repairBusy_o = (r_state == REPAIR_RUN) || (r_state == REPAIR_DRAIN);
  assign repairDone_o = (r_state == REPAIR_DRAIN) && !recoverFlag_i;

  for (genvar i = 0; i < N_PACKETS; i++) begin : g_lane
    logic [31:0]      w_slot;
    logic [INDEX-1:0] w_addr;
    logic             w_we;

    assign w_slot = w_base_ext + 32'(i);
    assign w_addr = w_slot[INDEX-1:0];
    // Tail lanes past DEPTH still read but never write.
    assign w_we   = w_run && (w_slot < 32'(DEPTH));
    assign amtAddr_o[i*INDEX +: INDEX] = w_run ? w_addr : '0;

    repair_lane #(
      .INDEX (INDEX),
      .WIDTH (WIDTH)
    ) u_lane (
      .clk     (clk),
      .reset_n (reset_n),
      .load_i  (w_run),
      .we_i    (w_we),
      .addr_i  (w_addr),
      .data_i  (amtData_i[i*WIDTH +: WIDTH]),
      .addr_o  (repairAddr_o[i*INDEX +: INDEX]),
      .data_o  (repairData_o[i*WIDTH +: WIDTH]),
      .we_o    (repairWe_o[i])
    );
  end

endmodule

// File: tb/tb_rename_repair_seq.sv
// Directed bench: default 32-entry instance and a 34-entry instance with a partial last beat.
// AMT model returns address+32 so every written tag is traceable to its entry.
module tb_rename_repair_seq;

  localparam int NP = 8;
  localparam int WA = 5;
  localparam int WB = 6;
  localparam int TW = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_a, rst_b, rec_a, rec_b;
  logic [NP*WA-1:0] amt_addr_a, rep_addr_a;
  logic [NP*WB-1:0] amt_addr_b, rep_addr_b;
  logic [NP*TW-1:0] amt_dat_a, amt_dat_b, rep_dat_a, rep_dat_b;
  logic [NP-1:0]    we_a, we_b;
  logic             busy_a, busy_b, done_a, done_b;

  rename_repair_seq dut_a (
    .clk(clk), .reset_n(rst_a), .recoverFlag_i(rec_a),
    .amtAddr_o(amt_addr_a), .amtData_i(amt_dat_a),
    .repairAddr_o(rep_addr_a), .repairData_o(rep_dat_a), .repairWe_o(we_a),
    .repairBusy_o(busy_a), .repairDone_o(done_a)
  );

  rename_repair_seq #(.DEPTH(34), .INDEX(WB), .WIDTH(TW), .N_PACKETS(NP)) dut_b (
    .clk(clk), .reset_n(rst_b), .recoverFlag_i(rec_b),
    .amtAddr_o(amt_addr_b), .amtData_i(amt_dat_b),
    .repairAddr_o(rep_addr_b), .repairData_o(rep_dat_b), .repairWe_o(we_b),
    .repairBusy_o(busy_b), .repairDone_o(done_b)
  );

  always_comb begin
    amt_dat_a = '0;
    amt_dat_b = '0;
    for (int i = 0; i < NP; i++) begin
      amt_dat_a[i*TW +: TW] = 7'(amt_addr_a[i*WA +: WA]) + 7'd32;
      amt_dat_b[i*TW +: TW] = 7'(amt_addr_b[i*WB +: WB]) + 7'd32;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] exp_bus(input int base, input int off, input int w);
    logic [63:0] r = '0;
    for (int i = 0; i < NP; i++)
      r |= (64'(base + i + off) & ((64'd1 << w) - 64'd1)) << (i * w);
    return r;
  endfunction

  function automatic logic [63:0] lane_mask(input logic [7:0] we, input int w);
    logic [63:0] r = '0;
    for (int i = 0; i < NP; i++)
      if (we[i]) r |= ((64'd1 << w) - 64'd1) << (i * w);
    return r;
  endfunction

  int rec_q[$], rst_q[$], amt_q[$], wb_q[$], we_q[$], busy_q[$], done_q[$], zero_q[$];

  task automatic run_scen(input string name, input bit use_b);
    logic [63:0] o_amt, o_addr, o_data, m_addr, m_data;
    logic [7:0]  o_we;
    logic        o_busy, o_done;
    int          w;
    w = use_b ? WB : WA;
    for (int c = 0; c < amt_q.size(); c++) begin
      if (use_b) rec_b = rec_q[c][0];
      else begin
        rec_a = rec_q[c][0];
        rst_a = !rst_q[c][0];
      end
      @(negedge clk);
      o_amt  = use_b ? 64'(amt_addr_b) : 64'(amt_addr_a);
      o_addr = use_b ? 64'(rep_addr_b) : 64'(rep_addr_a);
      o_data = use_b ? 64'(rep_dat_b)  : 64'(rep_dat_a);
      o_we   = use_b ? we_b   : we_a;
      o_busy = use_b ? busy_b : busy_a;
      o_done = use_b ? done_b : done_a;
      chk($sformatf("%s c%0d busy", name, c), 64'(o_busy), 64'(busy_q[c]));
      chk($sformatf("%s c%0d done", name, c), 64'(o_done), 64'(done_q[c]));
      chk($sformatf("%s c%0d we", name, c), 64'(o_we), 64'(we_q[c]));
      chk($sformatf("%s c%0d amtAddr", name, c), o_amt,
          (amt_q[c] < 0) ? 64'd0 : exp_bus(amt_q[c], 0, w));
      if (we_q[c] != 0) begin
        m_addr = lane_mask(8'(we_q[c]), w);
        m_data = lane_mask(8'(we_q[c]), TW);
        chk($sformatf("%s c%0d addr", name, c), o_addr & m_addr, exp_bus(wb_q[c], 0, w) & m_addr);
        chk($sformatf("%s c%0d data", name, c), o_data & m_data, exp_bus(wb_q[c], 32, TW) & m_data);
      end
      if (zero_q[c] != 0) begin
        chk($sformatf("%s c%0d addr0", name, c), o_addr, 64'd0);
        chk($sformatf("%s c%0d data0", name, c), o_data, 64'd0);
      end
      @(posedge clk); #1;
    end
    rec_a = 1'b0;
    rec_b = 1'b0;
    rst_a = 1'b1;
  endtask

  initial begin
    rst_a = 1'b0; rst_b = 1'b0; rec_a = 1'b1; rec_b = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset a ctl", {61'd0, we_a != 0, busy_a, done_a}, 64'd0);
    chk("reset a addr", 64'(rep_addr_a), 64'd0);
    chk("reset a data", 64'(rep_dat_a), 64'd0);
    chk("reset b ctl", {61'd0, we_b != 0, busy_b, done_b}, 64'd0);
    @(posedge clk); #1;
    rst_a = 1'b1; rst_b = 1'b1; rec_a = 1'b0; rec_b = 1'b0;
    @(posedge clk); #1;

    // Full default repair.
    rec_q  = '{1, 0, 0, 0, 0, 0, 0};
    rst_q  = '{0, 0, 0, 0, 0, 0, 0};
    amt_q  = '{-1, 0, 8, 16, 24, -1, -1};
    wb_q   = '{-1, -1, 0, 8, 16, 24, -1};
    we_q   = '{0, 0, 'hFF, 'hFF, 'hFF, 'hFF, 0};
    busy_q = '{0, 1, 1, 1, 1, 1, 0};
    done_q = '{0, 0, 0, 0, 0, 1, 0};
    zero_q = '{0, 0, 0, 0, 0, 0, 0};
    run_scen("full", 1'b0);

    // DEPTH 34: fifth beat writes only lanes 0-1.
    rec_q  = '{1, 0, 0, 0, 0, 0, 0, 0};
    rst_q  = '{0, 0, 0, 0, 0, 0, 0, 0};
    amt_q  = '{-1, 0, 8, 16, 24, 32, -1, -1};
    wb_q   = '{-1, -1, 0, 8, 16, 24, 32, -1};
    we_q   = '{0, 0, 'hFF, 'hFF, 'hFF, 'hFF, 'h03, 0};
    busy_q = '{0, 1, 1, 1, 1, 1, 1, 0};
    done_q = '{0, 0, 0, 0, 0, 0, 1, 0};
    zero_q = '{0, 0, 0, 0, 0, 0, 0, 0};
    run_scen("d34", 1'b1);

    // Restart during RUN at c3.
    rec_q  = '{1, 0, 0, 1, 0, 0, 0, 0, 0, 0};
    rst_q  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    amt_q  = '{-1, 0, 8, 16, 0, 8, 16, 24, -1, -1};
    wb_q   = '{-1, -1, 0, 8, 16, 0, 8, 16, 24, -1};
    we_q   = '{0, 0, 'hFF, 'hFF, 'hFF, 'hFF, 'hFF, 'hFF, 'hFF, 0};
    busy_q = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 0};
    done_q = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
    zero_q = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    run_scen("rerun", 1'b0);

    // Restart during DRAIN at c5.
    rec_q  = '{1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
    rst_q  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    amt_q  = '{-1, 0, 8, 16, 24, -1, 0, 8, 16, 24, -1, -1};
    wb_q   = '{-1, -1, 0, 8, 16, 24, -1, 0, 8, 16, 24, -1};
    we_q   = '{0, 0, 'hFF, 'hFF, 'hFF, 'hFF, 0, 'hFF, 'hFF, 'hFF, 'hFF, 0};
    busy_q = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
    done_q = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
    zero_q = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    run_scen("drain", 1'b0);

    // Reset asserted during c3 of a repair.
    rec_q  = '{1, 0, 0, 0, 0, 0, 0, 0, 0};
    rst_q  = '{0, 0, 0, 1, 0, 0, 0, 0, 0};
    amt_q  = '{-1, 0, 8, 16, -1, -1, -1, -1, -1};
    wb_q   = '{-1, -1, 0, 8, -1, -1, -1, -1, -1};
    we_q   = '{0, 0, 'hFF, 'hFF, 0, 0, 0, 0, 0};
    busy_q = '{0, 1, 1, 1, 0, 0, 0, 0, 0};
    done_q = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    zero_q = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
    run_scen("rst", 1'b0);

    // Idle soak.
    rec_a = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      chk($sformatf("soak c%0d", c), {61'd0, we_a != 0, busy_a, done_a}, 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
